// File: rtl/sd_sector_buffer.sv
// sd_sector_buffer
//   Bridges a host-side 512-byte sector buffer to a byte-serial SD card
//   controller. A host request starts a READ (controller bytes are stored
//   into the buffer) or a WRITE (buffer bytes are streamed to the
//   controller). A watchdog aborts a transfer when the controller stops
//   delivering bytes.
//
//   State   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | waiting for a request; host may write the buffer
//   ISSUE   | one-cycle execute strobe to the controller
//   XFER    | counting controller byte pulses, watchdog running
//   DONE    | one-cycle done pulse
//   ERROR   | one-cycle error state, err becomes set
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req, req_op, req_sector       sector request (op 0=READ, 1=WRITE)
//   req_ready, done, err          request handshake and status
//   buf_addr/wdata/we, buf_rdata  host buffer port (registered read)
//   ctl_*                         SD controller interface
//
// WD_BITS sets the watchdog width (20 in the real part).

module sd_sector_buffer #(
  parameter int WD_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_op,
  input  logic [25:0] req_sector,
  output logic        req_ready,
  output logic        done,
  output logic        err,
  input  logic [8:0]  buf_addr,
  input  logic [7:0]  buf_wdata,
  input  logic        buf_we,
  output logic [7:0]  buf_rdata,
  output logic        ctl_op_code,
  output logic        ctl_execute,
  output logic [25:0] ctl_sector_address,
  output logic [7:0]  ctl_outgoing_byte,
  input  logic [7:0]  ctl_incoming_byte,
  input  logic        ctl_finished_byte,
  input  logic        ctl_finished_sector,
  input  logic        ctl_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_XFER,
    S_DONE,
    S_ERROR
  } state_t;

  // Trip one count early so the register lands on all-ones exactly when
  // the allowed number of silent XFER cycles has elapsed.
  localparam logic [WD_BITS-1:0] WD_TRIP = {{(WD_BITS-1){1'b1}}, 1'b0};
  localparam logic [WD_BITS-1:0] WD_ONE  = {{(WD_BITS-1){1'b0}}, 1'b1};

  state_t state, state_nxt;

  logic [7:0]         mem [512];
  logic [9:0]         byte_cnt, byte_cnt_nxt;
  logic [WD_BITS-1:0] wd;

  logic       accept;
  logic       byte_hit;
  logic       rd_store;
  logic       rd_overrun;
  logic       mem_we;
  logic [8:0] mem_waddr;
  logic [7:0] mem_wdata;

  assign accept     = (state == S_IDLE) && req && !ctl_busy;
  assign byte_hit   = (state == S_XFER) && ctl_finished_byte;
  assign rd_store   = byte_hit && !ctl_op_code && !byte_cnt[9];
  assign rd_overrun = byte_hit && !ctl_op_code && byte_cnt[9];

  // Byte count including any pulse arriving this cycle; READ stops at 512,
  // WRITE saturates so a runaway controller cannot wrap back to 512.
  always_comb begin
    byte_cnt_nxt = byte_cnt;
    if (byte_hit) begin
      if (ctl_op_code) begin
        if (byte_cnt != 10'h3FF) byte_cnt_nxt = byte_cnt + 10'd1;
      end else if (!byte_cnt[9]) begin
        byte_cnt_nxt = byte_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    done        = 1'b0;
    ctl_execute = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (accept) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        ctl_execute = 1'b1;
        state_nxt   = S_XFER;
      end
      S_XFER: begin
        if (ctl_finished_sector)
          state_nxt = (byte_cnt_nxt == 10'd512) ? S_DONE : S_ERROR;
        else if (!ctl_finished_byte && (wd == WD_TRIP))
          state_nxt = S_ERROR;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERROR: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Host writes only in IDLE, controller writes only in XFER, so the single
  // write port never sees both at once.
  assign mem_we    = !rst && (rd_store || ((state == S_IDLE) && buf_we));
  assign mem_waddr = rd_store ? byte_cnt[8:0] : buf_addr;
  assign mem_wdata = rd_store ? ctl_incoming_byte : buf_wdata;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) buf_rdata <= 8'h00;
    else     buf_rdata <= mem[buf_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt           <= 10'd0;
      wd                 <= '0;
      err                <= 1'b0;
      ctl_op_code        <= 1'b0;
      ctl_sector_address <= 26'd0;
      ctl_outgoing_byte  <= 8'hFF;
    end else begin
      if (accept) begin
        ctl_op_code        <= req_op;
        ctl_sector_address <= req_sector;
        byte_cnt           <= 10'd0;
        wd                 <= '0;
        err                <= 1'b0;
      end else begin
        byte_cnt <= byte_cnt_nxt;
        if (state == S_XFER) wd <= ctl_finished_byte ? '0 : wd + WD_ONE;
        if ((state == S_ERROR) || rd_overrun) err <= 1'b1;
      end

      // Outgoing byte always presents the next byte the controller will take.
      if (state == S_ISSUE)
        ctl_outgoing_byte <= mem[0];
      else if (byte_hit && ctl_op_code)
        ctl_outgoing_byte <= (byte_cnt >= 10'd511) ? 8'hFF : mem[byte_cnt[8:0] + 9'd1];
    end
  end

endmodule
